// File: rtl/instr_mem_loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction memory loader: FSM state encoding,
// default memory depth and the byte/word widths used by the datapath.
// The CHECK state only exists when LOADER_CHECKSUM_EN is defined.
// ----------------------------------------------------------------------------
package loader_pkg;

    localparam int MEM_DEPTH_DEF = 256;
    localparam int WORD_W        = 32;
    localparam int BYTE_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK   = 3'd3,
`endif
        ST_FINISH  = 3'd4
    } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// ----------------------------------------------------------------------------
// instr_mem_loader_if
// Bundle of the loader's control, byte-stream and memory-write signals.
//   master : the environment (drives start/length/byte stream)
//   slave  : the loader (drives byte_ready, write port and status)
// Parameter AW is the word address width; length is AW+1 bits wide so that
// a full-memory load (MEM_DEPTH words) can be expressed.
// ----------------------------------------------------------------------------
interface instr_mem_loader_if #(
    parameter int AW = 8
);
    logic          start;
    logic [AW:0]   length;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;

    modport master (
        output start, length, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error
    );

    modport slave (
        input  start, length, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, error
    );
endinterface

// File: rtl/instr_mem_loader_word_packer.sv
// ----------------------------------------------------------------------------
// word_packer
// Assembles four accepted bytes into one little-endian 32-bit word.
// Ports:
//   clk, rst          clock / async active-high reset
//   clear_i           synchronous clear of word and byte counter
//   accept_i          a byte is accepted this cycle
//   byte_i            byte to pack
//   word_o            assembled word (first byte in bits [7:0])
//   word_complete_o   the byte accepted this cycle completes the word
// ----------------------------------------------------------------------------
module word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_complete_o
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Next-state: shift new bytes in from the top so the first byte ends up
    // in the least significant position after four accepts.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = 2'd0;
            word_d = {WORD_W{1'b0}};
        end else if (accept_i) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {byte_i, word_q[WORD_W-1:BYTE_W]};
        end else begin
            cnt_d  = cnt_q;
            word_d = word_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= {WORD_W{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o          = word_q;
    assign word_complete_o = accept_i & ~clear_i & (cnt_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Receives a byte stream, packs it into 32-bit instruction words and writes
// them to consecutive instruction-memory addresses starting at 0.
// Ports:
//   clk   system clock (rising edge)
//   rst   asynchronous active-high reset
//   bus   instr_mem_loader_if.slave: start/length request, byte stream
//         (byte_in/byte_valid/byte_ready), write port (wr_en/wr_addr/
//         wr_data) and status (busy/done/error)
// Configuration:
//   LOADER_CHECKSUM_EN  when defined, one extra byte after the program is
//                       compared against the XOR of all program bytes and a
//                       mismatch sets error; otherwise error is tied to 0.
// ----------------------------------------------------------------------------
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    instr_mem_loader_if.slave   bus
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW:0]       len_q, len_d;
    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_s;
    logic              accept_s;
    logic              last_word_s;
    logic              word_complete_s;
    logic [WORD_W-1:0] word_s;

    assign start_s     = bus.start & (state_q == ST_IDLE);
    assign accept_s    = bus.byte_valid & ready_q;
    // Words written after this WRITE equals the (clamped) length.
    assign last_word_s = (((AW+1)'(addr_q)) + (AW+1)'(1)) == len_q;

    word_packer u_packer (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (start_s),
        .accept_i        (accept_s & (state_q == ST_COLLECT)),
        .byte_i          (bus.byte_in),
        .word_o          (word_s),
        .word_complete_o (word_complete_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.length == {(AW+1){1'b0}}) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (word_complete_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_FINISH;
`endif
                end else begin
                    state_d = ST_COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state so the registered outputs line
    // up with the state they belong to.
    always_comb begin
        ready_d = 1'b0;
        wr_en_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state_d)
            ST_IDLE:    busy_d  = 1'b0;
            ST_COLLECT: ready_d = 1'b1;
            ST_WRITE:   wr_en_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK:   ready_d = 1'b1;
`endif
            ST_FINISH:  done_d  = 1'b1;
            default:    busy_d  = 1'b0;
        endcase
    end

    // Address and length next-state; the address stops at the last word so
    // it never wraps past MEM_DEPTH-1.
    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        if (start_s) begin
            addr_d = {AW{1'b0}};
            if (bus.length > (AW+1)'(MEM_DEPTH)) begin
                len_d = (AW+1)'(MEM_DEPTH);
            end else begin
                len_d = bus.length;
            end
        end else if ((state_q == ST_WRITE) && !last_word_s) begin
            addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            addr_d = addr_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= {AW{1'b0}};
            len_q   <= {(AW+1){1'b0}};
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            ready_q <= ready_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              error_q, error_d;

    // Running XOR of program bytes and the checksum comparison.
    always_comb begin
        csum_d  = csum_q;
        error_d = error_q;
        if (start_s) begin
            csum_d  = {BYTE_W{1'b0}};
            error_d = 1'b0;
        end else if (accept_s && (state_q == ST_COLLECT)) begin
            csum_d  = csum_q ^ bus.byte_in;
        end else if (accept_s && (state_q == ST_CHECK)) begin
            error_d = (bus.byte_in != csum_q);
        end else begin
            csum_d  = csum_q;
            error_d = error_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q  <= {BYTE_W{1'b0}};
            error_q <= 1'b0;
        end else begin
            csum_q  <= csum_d;
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.byte_ready = ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = word_s;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader (MEM_DEPTH = 256). Table of load
// scenarios plus hand-written sequences for timing, stall, reset and
// checksum corners. Works with or without LOADER_CHECKSUM_EN.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

    logic clk;
    logic rst;

    instr_mem_loader_if #(.AW(8)) bus ();

    instr_mem_loader #(.MEM_DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          len;
        int          gap;
        logic [7:0]  seed;
        int          exp_writes;
        int          exp_last;
        logic [31:0] exp_w0;
        int          exp_busy;
    } ld_vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    int done_cnt = 0;
    int busy_cnt = 0;
    int rdy_viol = 0;

    // Write/status monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            if (bus.byte_ready) rdy_viol++;
        end
        if (bus.done) done_cnt++;
        if (bus.busy) busy_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [7:0] seed, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return seed + kb;
    endfunction

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        done_cnt = 0;
        busy_cnt = 0;
        rdy_viol = 0;
    endtask

    // Present one byte and hold it until it has been accepted.
    task automatic feed(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.byte_ready) chk("feed_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        bus.start  = 1'b1;
        bus.length = 9'(len);
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    task automatic run_load(input string tag, input ld_vec_t v);
        int k;
        int cyc;
        int total;
        int bad;
        logic [7:0]  cs;
        logic [31:0] ew;
        clear_mon();
        total = 4 * v.exp_writes;
`ifdef LOADER_CHECKSUM_EN
        if (v.exp_writes != 0) total = total + 1;
`endif
        pulse_start(v.len);
        k   = 0;
        cyc = 0;
        cs  = 8'h00;
        while (done_cnt == 0 && cyc < 5000) begin
            if (k < 4 * v.exp_writes) bus.byte_in = byte_of(v.seed, k);
            else                      bus.byte_in = cs;
            bus.byte_valid = ((v.gap == 0) || (cyc % (v.gap + 1) == 0)) && (k < total);
            if (bus.byte_valid && bus.byte_ready) begin
                if (k < 4 * v.exp_writes) cs = cs ^ bus.byte_in;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.byte_valid = 1'b0;
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_writes"}, 64'(wa.size()), 64'(v.exp_writes));
        if (v.exp_writes > 0) begin
            chk({tag, "_last_addr"}, 64'(wa[wa.size()-1]), 64'(v.exp_last));
            chk({tag, "_word0"}, 64'(wd[0]), 64'(v.exp_w0));
        end
        bad = 0;
        for (int i = 0; i < wa.size(); i++) begin
            ew = {byte_of(v.seed, 4*i+3), byte_of(v.seed, 4*i+2),
                  byte_of(v.seed, 4*i+1), byte_of(v.seed, 4*i)};
            if (wa[i] !== 8'(i) || wd[i] !== ew) bad++;
        end
        chk({tag, "_word_seq"}, 64'(bad), 64'd0);
        chk({tag, "_ready_in_write"}, 64'(rdy_viol), 64'd0);
        if (v.exp_busy != 0) chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_busy));
        chk({tag, "_error"}, 64'(bus.error), 64'd0);
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    ld_vec_t vecs[5];

    initial begin
        vecs[0] = '{len: 2,   gap: 0, seed: 8'h10, exp_writes: 2,   exp_last: 1,   exp_w0: 32'h13121110, exp_busy: 0};
        vecs[1] = '{len: 3,   gap: 1, seed: 8'hA0, exp_writes: 3,   exp_last: 2,   exp_w0: 32'hA3A2A1A0, exp_busy: 0};
        vecs[2] = '{len: 0,   gap: 0, seed: 8'h00, exp_writes: 0,   exp_last: 0,   exp_w0: 32'h00000000, exp_busy: 1};
        vecs[3] = '{len: 300, gap: 0, seed: 8'h00, exp_writes: 256, exp_last: 255, exp_w0: 32'h03020100, exp_busy: 0};
        vecs[4] = '{len: 5,   gap: 2, seed: 8'hFC, exp_writes: 5,   exp_last: 4,   exp_w0: 32'hFFFEFDFC, exp_busy: 0};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.length     = 9'd0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.byte_ready), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_done",  64'(bus.done), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_addr",  64'(bus.wr_addr), 64'd0);
        chk("rst_data",  64'(bus.wr_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single word 13,00,00,00 with exact strobe/done timing.
        clear_mon();
        pulse_start(1);
        chk("w1_ready", 64'(bus.byte_ready), 64'd1);
        chk("w1_busy",  64'(bus.busy), 64'd1);
        feed(8'h13);
        feed(8'h00);
        feed(8'h00);
        feed(8'h00);
        chk("w1_wr_en",  64'(bus.wr_en), 64'd1);
        chk("w1_addr",   64'(bus.wr_addr), 64'd0);
        chk("w1_data",   64'(bus.wr_data), 64'h13);
        chk("w1_ready_w", 64'(bus.byte_ready), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        chk("w1_check_ready", 64'(bus.byte_ready), 64'd1);
        feed(8'h13);
`else
        @(posedge clk); #1;
`endif
        chk("w1_done",   64'(bus.done), 64'd1);
        chk("w1_wr_off", 64'(bus.wr_en), 64'd0);
        @(posedge clk); #1;
        chk("w1_done_off", 64'(bus.done), 64'd0);
        chk("w1_idle",     64'(bus.busy), 64'd0);
        chk("w1_nwrites",  64'(wa.size()), 64'd1);

        // Table-driven loads.
        for (int i = 0; i < 5; i++) begin
            run_load($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk); #1;
        end

        // Stall with partial word retained; a Start mid-load is ignored.
        clear_mon();
        pulse_start(1);
        feed(8'h78);
        feed(8'h56);
        for (int i = 0; i < 8; i++) begin
            bus.start  = (i == 3);
            bus.length = 9'd0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("stall_busy",   64'(bus.busy), 64'd1);
        chk("stall_ready",  64'(bus.byte_ready), 64'd1);
        chk("stall_nodone", 64'(done_cnt), 64'd0);
        chk("stall_nowr",   64'(wa.size()), 64'd0);
        feed(8'h34);
        feed(8'h12);
        chk("stall_wr_en", 64'(bus.wr_en), 64'd1);
        chk("stall_data",  64'(bus.wr_data), 64'h12345678);
`ifdef LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        feed(8'h08);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("stall_done_once", 64'(done_cnt), 64'd1);
        chk("stall_writes",    64'(wa.size()), 64'd1);

        // Reset after two bytes of the first word.
        clear_mon();
        pulse_start(2);
        feed(8'hAA);
        feed(8'hBB);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  64'(bus.busy), 64'd0);
        chk("mid_rst_ready", 64'(bus.byte_ready), 64'd0);
        chk("mid_rst_data",  64'(bus.wr_data), 64'd0);
        chk("mid_rst_addr",  64'(bus.wr_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_nowr", 64'(wa.size()), 64'd0);
        run_load("after_rst", '{len: 1, gap: 0, seed: 8'h40, exp_writes: 1, exp_last: 0, exp_w0: 32'h43424140, exp_busy: 0});

`ifdef LOADER_CHECKSUM_EN
        // Checksum good (0x04) then bad (0x05).
        pulse_start(1);
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        @(posedge clk); #1;
        feed(8'h04);
        chk("cs_good_done",  64'(bus.done), 64'd1);
        chk("cs_good_error", 64'(bus.error), 64'd0);
        @(posedge clk); #1;
        pulse_start(1);
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        @(posedge clk); #1;
        feed(8'h05);
        chk("cs_bad_done",  64'(bus.done), 64'd1);
        chk("cs_bad_error", 64'(bus.error), 64'd1);
        @(posedge clk); #1;
        chk("cs_bad_sticky", 64'(bus.error), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
